// File: rtl/beep_scheduler_if.sv
// rtl/beep_scheduler_if.sv - requester handshake bundle for beep_scheduler
interface beep_scheduler_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0][7:0] req_ms;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;

    modport master (output req, output req_ms, input gnt, input done);
    modport slave  (input req, input req_ms, output gnt, output done);
endinterface

// File: rtl/beep_scheduler.sv
// rtl/beep_scheduler.sv - timed beep arbiter/sequencer with CPU manual beeper override
// Optional macro BEEP_RR_EN: round-robin arbitration instead of lowest-index-wins.
module beep_scheduler #(
    parameter int NREQ   = 3,
    parameter int MS_DIV = 64000,
    parameter int GAP_MS = 2
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce,
    input  logic            tone,
    input  logic            cpu_wr,
    input  logic [7:0]      cpu_data,
    beep_scheduler_if.slave bus,
    output logic            busy,
    output logic            speaker_en,
    output logic            speaker
);
    localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(MS_DIV - 1);
    localparam logic [7:0]    GAP_LAST   = 8'(GAP_MS - 1);

    typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      gap_q, gap_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            timed_q, timed_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            cpu_on_q;
    logic            found;
    logic [IW-1:0]   sel;
    logic            tick;

    assign tick = ce && (presc_q == PRESC_LAST);

`ifdef BEEP_RR_EN
    logic [IW-1:0] rr_q;

    // Search begins one past the last winner, wrapping at NREQ.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_q) + 1 + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rr_q <= IW'(NREQ - 1);
        end else if (state_q == IDLE && found) begin
            rr_q <= sel;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[IW'(k)]) begin
                found = 1'b1;
                sel   = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        gap_d       = gap_q;
        owner_d     = owner_q;
        timed_d     = timed_q;
        gnt_d       = '0;
        done_d      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BEEP;
                    gnt_d       = NREQ'(1) << sel;
                    remaining_d = bus.req_ms[sel];
                    presc_d     = '0;
                    owner_d     = sel;
                    timed_d     = (bus.req_ms[sel] != 8'd0);
                end
            end
            BEEP: begin
                if (remaining_q == 8'd0) begin
                    // Zero-length request: complete immediately, never enable the speaker.
                    state_d = IDLE;
                    done_d  = NREQ'(1) << owner_q;
                end else begin
                    if (ce) presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        remaining_d = remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            timed_d = 1'b0;
                            done_d  = NREQ'(1) << owner_q;
                            gap_d   = '0;
                            state_d = (GAP_MS == 0) ? IDLE : GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (ce) presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (gap_q == GAP_LAST) state_d = IDLE;
                    else                   gap_d   = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            presc_q     <= '0;
            gap_q       <= '0;
            owner_q     <= '0;
            timed_q     <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            gap_q       <= gap_d;
            owner_q     <= owner_d;
            timed_q     <= timed_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_on_q <= 1'b0;
        end else if (cpu_wr) begin
            if (cpu_data == 8'h0B)      cpu_on_q <= 1'b1;
            else if (cpu_data == 8'h0C) cpu_on_q <= 1'b0;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign busy       = (state_q != IDLE);
    assign speaker_en = timed_q | cpu_on_q;
    assign speaker    = tone & speaker_en;
endmodule

// File: doc/beep_scheduler.md
# beep_scheduler

Sequencer and arbiter for the PCW beeper tone path. Accepts timed beep requests from several internal requesters (bell, key click, disc-error alert, …) plus the CPU's manual beeper on/off commands, and grants the single speaker to one requester at a time for a programmed duration. It outputs the gated speaker bit and a speaker enable for the tone generator.

## Interface
Parameters:
- `NREQ`, default 3: number of timed-beep requesters.
- `MS_DIV`, default 64000: `ce` pulses per 1 ms duration tick.
- `GAP_MS`, default 2: forced silence in ms between consecutive timed beeps; 0 disables the gap.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: clock enable; all duration/gap timing advances only on `ce`=1 cycles.
- `tone` in 1: square wave from the tone generator.
- `cpu_wr` in 1: one-cycle CPU write strobe to port F8h.
- `cpu_data` in 8: write data. 0Bh = beeper on, 0Ch = beeper off.
- `req` in NREQ: per-requester level request, held until `gnt`.
- `req_ms` in NREQ×8: per-requester duration in ms, sampled on grant.
- `gnt` out NREQ: one-cycle grant pulse, one-hot.
- `done` out NREQ: one-cycle completion pulse, one-hot.
- `busy` out 1: high in BEEP or GAP.
- `speaker_en` out 1: timed beep active OR manual beeper on.
- `speaker` out 1: `tone` AND `speaker_en`, combinational.

## Operation
- FSM states are IDLE, BEEP and GAP. Arbitration happens in IDLE only.
- IDLE with any `req` bit set, sampled at edge N, with `ce` ignored:
  - At N+1: `gnt[i]`=1 for one cycle, state BEEP, `remaining`=`req_ms[i]`, ms prescaler cleared to 0, `owner`=i.
- `req_ms[i]`=0:
  - Grant as normal, state BEEP for one cycle, `done[i]` at N+2, return to IDLE. No GAP.
  - `speaker_en` is never raised by the timed path in this case.
- BEEP:
  - The prescaler counts `ce` pulses 0..MS_DIV-1. Each wrap is a tick; each tick decrements `remaining`.
  - On the tick where `remaining`==1: `done[owner]`=1 next cycle, and the timed enable drops on the same edge.
  - Then enter GAP, or IDLE if `GAP_MS`=0.
- GAP: counts `GAP_MS` ticks with the prescaler restarted at 0, then enters IDLE.
- A `req` still high in the `gnt` cycle is not re-granted; the requester must drop it within that cycle.
- Manual beeper:
  - `cpu_wr` with 0Bh sets `cpu_on`; with 0Ch clears it. Any other value is ignored.
  - `cpu_on` is ORed into `speaker_en` and is independent of the FSM. Timed beeps still run and complete normally under it.
- Widths: `remaining` is 8 bits. The prescaler is `$clog2(MS_DIV)` bits. The gap counter is 8 bits.
- Reset:
  - State IDLE; `gnt`, `done`, `busy`, `speaker_en`, `cpu_on` all 0.
  - Round-robin pointer = NREQ-1.
  - An in-progress beep is abandoned with no `done` pulse.

## Timing
- `req` to `gnt`: 1 cycle. `gnt` and `speaker_en` rise on the same edge.
- Timed `speaker_en` high time = `req_ms` × `MS_DIV` `ce` pulses exactly.
- `done` rises on the edge where `speaker_en` falls, unless `cpu_on` holds `speaker_en` high.
- `busy` rises with `gnt` and falls on entry to IDLE.
- Earliest next `gnt` is 1 cycle after `busy` falls.
- `cpu_wr` to `speaker_en` change: 1 cycle.
- `speaker` follows `tone` with zero latency while enabled.

## Configuration
- `BEEP_RR_EN` defined: round-robin arbitration. The search starts at index (last granted + 1) mod NREQ.
- Not defined: fixed priority, where the lowest index wins. The round-robin pointer logic is not compiled.

## Test plan
All scenarios use `MS_DIV`=4, `GAP_MS`=2, `ce`=1 unless stated.
- `req`=010, `req_ms[1]`=3:
  - `gnt`=010 one cycle later.
  - `speaker_en` high 12 cycles; `done`=010 at its fall.
  - `busy` high 20 cycles.
- `req`=101 held, fixed priority: `gnt[0]` first; `gnt[2]` exactly 9 cycles after `done[0]` (8 gap + 1).
  - With `BEEP_RR_EN` and all `req` held: grant order 0,1,2,0.
- CPU writes:
  - 0Bh → `speaker_en`=1 next cycle, held through a timed beep's `done`.
  - 55h → no change.
  - 0Ch → `speaker_en`=0.
- `req_ms`=0: `gnt` then `done` next cycle; `speaker_en` never 1; `busy` high 1 cycle.
- `ce` toggling every other cycle with `req_ms`=2: `speaker_en` high 16 cycles.
- `reset` asserted 5 cycles into a beep: all outputs 0 next cycle; no `done`; a new `req` is granted normally afterwards.
